// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, mode constants and helpers for the bus arbiter mux
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Widest request vector the conflict helper accepts; callers zero-extend.
  localparam int MAX_SRC = 64;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [MAX_SRC-1:0] v);
    return |(v & (v - MAX_SRC'(1)));
  endfunction

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - combinational first-set search from a start index, or highest-first when reversed
module priority_pick #(
  parameter int N       = 24,
  parameter int SELW    = 5,
  parameter bit REVERSE = 1'b0
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  int c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      if (REVERSE) begin
        c = N - 1 - i;
      end else begin
        c = int'(start) + i;
        if (c >= N) c = c - N;
      end
      if (!found && req[SELW'(c)]) begin
        found = 1'b1;
        idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - registered multi-source bus arbiter with lock, idle hold and conflict counting
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NSRC  = 24,
  parameter  int MODE  = MODE_FIXED,
  localparam int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  lock,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SELW-1:0]       grant_idx,
  output logic                  conflict,
  output logic                  conflict_sticky,
  output logic [7:0]            conflict_cnt
);

  state_t           state;
  logic [SELW-1:0]  rr_last;
  logic [SELW-1:0]  rr_start;
  logic [SELW-1:0]  pick_start;
  logic [SELW-1:0]  win_idx;
  logic             found;
  logic             hold;
  logic             conf;

  always_comb begin
    rr_start   = (int'(rr_last) == NSRC - 1) ? '0 : rr_last + 1'b1;
    pick_start = (MODE == MODE_RR) ? rr_start : '0;
    // The owner keeps the bus only while it asserts its strobe under lock.
    hold       = (state != IDLE) && lock && src_req[grant_idx];
    conf       = more_than_one(MAX_SRC'(src_req));
  end

  priority_pick #(
    .N       (NSRC),
    .SELW    (SELW),
    .REVERSE (MODE == MODE_FIXED)
  ) u_pick (
    .req   (src_req),
    .start (pick_start),
    .found (found),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state           <= IDLE;
      rr_last         <= SELW'(NSRC - 1);
      bus_out         <= '0;
      bus_valid       <= 1'b0;
      grant_idx       <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= 8'd0;
    end else begin
      if (hold) begin
        state     <= LOCKED;
        bus_valid <= 1'b1;
        bus_out   <= src_data[grant_idx*WIDTH +: WIDTH];
      end else if (found) begin
        state     <= (state == IDLE && lock) ? LOCKED : OWN;
        bus_valid <= 1'b1;
        grant_idx <= win_idx;
        rr_last   <= win_idx;
        bus_out   <= src_data[win_idx*WIDTH +: WIDTH];
      end else begin
        state     <= IDLE;
        bus_valid <= 1'b0;
      end

      conflict <= conf;
      // A fresh conflict outranks a simultaneous clear so no event is lost.
      if (conf) begin
        conflict_sticky <= 1'b1;
        if (err_clr)
          conflict_cnt <= 8'd1;
        else if (conflict_cnt != 8'hFF)
          conflict_cnt <= conflict_cnt + 8'd1;
      end else if (err_clr) begin
        conflict_sticky <= 1'b0;
        conflict_cnt    <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - scoreboard bench running fixed and round-robin instances side by side
module tb_bus_arbiter_mux;

  localparam int W    = 32;
  localparam int NSRC = 24;
  localparam int SELW = 5;

  logic                 clk = 1'b0;
  logic                 clr_n = 1'b0;
  logic [NSRC-1:0]      src_req = '0;
  logic [NSRC*W-1:0]    src_data = '0;
  logic                 lock = 1'b0;
  logic                 err_clr = 1'b0;

  logic [W-1:0]    fx_bus, rr_bus;
  logic            fx_valid, rr_valid;
  logic [SELW-1:0] fx_gidx, rr_gidx;
  logic            fx_conf, rr_conf;
  logic            fx_sticky, rr_sticky;
  logic [7:0]      fx_cnt, rr_cnt;

  always #5 clk = ~clk;

  bus_arbiter_mux #(.WIDTH(W), .NSRC(NSRC), .MODE(0)) dut_fx (
    .clk(clk), .clr_n(clr_n), .src_req(src_req), .src_data(src_data),
    .lock(lock), .err_clr(err_clr), .bus_out(fx_bus), .bus_valid(fx_valid),
    .grant_idx(fx_gidx), .conflict(fx_conf), .conflict_sticky(fx_sticky),
    .conflict_cnt(fx_cnt)
  );

  bus_arbiter_mux #(.WIDTH(W), .NSRC(NSRC), .MODE(1)) dut_rr (
    .clk(clk), .clr_n(clr_n), .src_req(src_req), .src_data(src_data),
    .lock(lock), .err_clr(err_clr), .bus_out(rr_bus), .bus_valid(rr_valid),
    .grant_idx(rr_gidx), .conflict(rr_conf), .conflict_sticky(rr_sticky),
    .conflict_cnt(rr_cnt)
  );

  typedef struct packed {
    logic [31:0] fx_bus;
    logic [31:0] rr_bus;
    logic        fx_valid;
    logic        rr_valid;
    logic [4:0]  fx_gidx;
    logic [4:0]  rr_gidx;
    logic        conf;
    logic        sticky;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] dat [NSRC];
  logic [31:0] m_bus [2];
  int          m_gidx [2];
  bit          m_busy [2];
  int          m_rr [2];
  int          m_cnt;
  bit          m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick(input int mode, input logic [NSRC-1:0] r, input int last);
    if (mode == 0) begin
      for (int i = NSRC - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        int i;
        i = (last + k) % NSRC;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_bus[m] = 0; m_gidx[m] = 0; m_busy[m] = 0; m_rr[m] = NSRC - 1;
    end
    m_cnt = 0;
    m_sticky = 0;
  endtask

  task automatic step(input logic [NSRC-1:0] r, input bit lk, input bit ec);
    exp_t e;
    int   w;
    @(negedge clk);
    for (int i = 0; i < NSRC; i++) src_data[i*W +: W] = dat[i];
    src_req = r;
    lock    = lk;
    err_clr = ec;
    for (int m = 0; m < 2; m++) begin
      if (m_busy[m] && lk && r[m_gidx[m]]) begin
        m_bus[m] = dat[m_gidx[m]];
      end else begin
        w = pick(m, r, m_rr[m]);
        if (w >= 0) begin
          m_busy[m] = 1; m_gidx[m] = w; m_rr[m] = w; m_bus[m] = dat[w];
        end else begin
          m_busy[m] = 0;
        end
      end
    end
    if ($countones(r) >= 2) begin
      m_sticky = 1;
      m_cnt = ec ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (ec) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    e.fx_bus = m_bus[0];  e.rr_bus = m_bus[1];
    e.fx_valid = m_busy[0]; e.rr_valid = m_busy[1];
    e.fx_gidx = 5'(m_gidx[0]); e.rr_gidx = 5'(m_gidx[1]);
    e.conf = ($countones(r) >= 2);
    e.sticky = m_sticky;
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr_n = 1'b0;
    src_req = '0; lock = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_fx_bus"}, fx_bus, 0);
    check({tag, "_fx_valid"}, 32'(fx_valid), 0);
    check({tag, "_fx_gidx"}, 32'(fx_gidx), 0);
    check({tag, "_fx_cnt"}, 32'(fx_cnt), 0);
    check({tag, "_fx_sticky"}, 32'(fx_sticky), 0);
    check({tag, "_rr_bus"}, rr_bus, 0);
    check({tag, "_rr_valid"}, 32'(rr_valid), 0);
    check({tag, "_rr_conf"}, 32'(rr_conf), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (clr_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fx_valid", 32'(fx_valid), 32'(e.fx_valid));
        check("fx_bus", fx_bus, e.fx_bus);
        check("fx_gidx", 32'(fx_gidx), 32'(e.fx_gidx));
        check("rr_valid", 32'(rr_valid), 32'(e.rr_valid));
        check("rr_bus", rr_bus, e.rr_bus);
        check("rr_gidx", 32'(rr_gidx), 32'(e.rr_gidx));
        check("conflict", 32'(fx_conf), 32'(e.conf));
        check("rr_conflict", 32'(rr_conf), 32'(e.conf));
        check("sticky", 32'(fx_sticky), 32'(e.sticky));
        check("cnt", 32'(fx_cnt), 32'(e.cnt));
        check("rr_cnt", 32'(rr_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [NSRC-1:0] r;
    model_reset();
    for (int i = 0; i < NSRC; i++) dat[i] = 32'(i);
    #12;
    reset_checks("por");
    @(negedge clk);
    clr_n = 1'b1;

    // Fixed priority among R3, R15, PC
    dat[3] = 32'h3; dat[15] = 32'hF; dat[20] = 32'h14;
    step(24'h108008, 0, 0);
    #2;
    check("fixed_bus", fx_bus, 32'h14);
    check("fixed_gidx", 32'(fx_gidx), 20);
    check("fixed_conf", 32'(fx_conf), 1);
    check("fixed_cnt", 32'(fx_cnt), 1);

    // Round-robin alternation between sources 2 and 5
    pulse_reset();
    begin
      int want [4] = '{2, 5, 2, 5};
      for (int k = 0; k < 4; k++) begin
        step(24'h000024, 0, 0);
        #2;
        check("rr_seq_gidx", 32'(rr_gidx), 32'(want[k]));
        check("rr_seq_valid", 32'(rr_valid), 1);
      end
    end
    check("rr_seq_cnt", 32'(rr_cnt), 4);

    // Lock on R7 while C_out joins, then release
    step(24'h000080, 1, 0);
    for (int k = 0; k < 3; k++) begin
      dat[7] = $urandom;
      step(24'h800080, 1, 0);
      #2;
      check("lock_hold_gidx", 32'(fx_gidx), 7);
    end
    step(24'h800080, 0, 0);
    #2;
    check("lock_release_gidx", 32'(fx_gidx), 23);

    // Idle hold after MDR drove the bus
    dat[21] = 32'hDEADBEEF;
    step(24'h200000, 0, 0);
    step(24'h000000, 0, 0);
    #2;
    check("idle_hold_bus", fx_bus, 32'hDEADBEEF);
    check("idle_hold_valid", 32'(fx_valid), 0);

    // Saturation and clear priority
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NSRC; i++) dat[i] = $urandom;
      step(NSRC'($urandom) | 24'h800001, 0, 0);
    end
    #2;
    check("sat_cnt", 32'(fx_cnt), 255);
    check("sat_sticky", 32'(fx_sticky), 1);
    step(24'h000011, 0, 1);
    #2;
    check("clr_with_conf_cnt", 32'(fx_cnt), 1);
    step(24'h000010, 0, 1);
    #2;
    check("clr_alone_cnt", 32'(fx_cnt), 0);
    check("clr_alone_sticky", 32'(fx_sticky), 0);

    // Randomized traffic with occasional lock and clear
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NSRC; i++) dat[i] = $urandom;
      r = NSRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 4) == 0) r = '0;
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in the middle of a lock
    step(24'h000020, 1, 0);
    step(24'h000220, 1, 0);
    #3;
    clr_n = 1'b0;
    #1;
    reset_checks("mid_lock");
    src_req = '0; lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    dat[0] = 32'h0A5A5A5A;
    step(24'h000001, 0, 0);
    #2;
    check("post_reset_rr_gidx", 32'(rr_gidx), 0);
    check("post_reset_rr_bus", rr_bus, 32'h0A5A5A5A);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
